ysyx_23060191_gpr_wb_arb: RTL

//  Shares the single GPR write port between the EXU (ALU/CSR result) and LSU (load data) writeback paths.

---
 rtl/ysyx_23060191_gpr_wb_arb_pkg.sv | 21 ++
 rtl/ysyx_23060191_rr_arb2.sv | 35 +++
 rtl/ysyx_23060191_gpr_wb_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/ysyx_23060191_gpr_wb_arb_pkg.sv
// Shared constants and types for the GPR writeback arbiter slice.
//   GPR_DATA_W : default GPR write data width
//   GPR_ADDR_W : register address width (fixed at 5)
//   GPR_NREG   : number of architectural registers
//   ARB_EXU / ARB_LSU : requester positions in the arbiter req/gnt vectors
package ysyx_23060191_gpr_wb_arb_pkg;

  localparam int unsigned GPR_DATA_W = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned GPR_NREG   = 32;

  localparam int unsigned ARB_EXU = 0;
  localparam int unsigned ARB_LSU = 1;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PRIO_EXU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

endpackage

// File: rtl/ysyx_23060191_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset (priority returns to EXU)
//   req[1:0]   : requests, indexed by ARB_EXU / ARB_LSU
//   gnt[1:0]   : combinational one-hot (or zero) grant
// A lone request is always granted. On contention the priority holder wins and
// priority passes to the loser; uncontended grants leave priority unchanged.
module ysyx_23060191_rr_arb2
  import ysyx_23060191_gpr_wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  prio_e prio;

  always_comb begin
    gnt = '0;
    if (req[ARB_EXU] && (!req[ARB_LSU] || prio == PRIO_EXU)) begin
      gnt[ARB_EXU] = 1'b1;
    end else if (req[ARB_LSU]) begin
      gnt[ARB_LSU] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_EXU;
    end else if (&req) begin
      prio <= gnt[ARB_EXU] ? PRIO_LSU : PRIO_EXU;
    end
  end

endmodule

// File: rtl/ysyx_23060191_gpr_wb_arb.sv
// GPR writeback arbiter with pending-write scoreboard.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_flush             : drop every pending bit (trap / redirect)
//   i_iss_*             : IDU issue request (valid, writes-rd, rd, rs1, rs2)
//   o_iss_stall         : RAW/WAW hazard against an in-flight write
//   i_exu_*, o_exu_ready: EXU writeback request and grant
//   i_lsu_*, o_lsu_ready: LSU writeback request and grant
//   o_wr_en_Rd, o_addr_Rd, o_data_Rd : registered GPR write port
//   o_wb_err            : sticky, a writeback hit a nonzero rd that was not pending
module ysyx_23060191_gpr_wb_arb
  import ysyx_23060191_gpr_wb_arb_pkg::*;
#(
  parameter int unsigned CPU_WIDTH = GPR_DATA_W,
  parameter int unsigned NREG      = GPR_NREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_iss_valid,
  input  logic                  i_iss_wen,
  input  logic [GPR_ADDR_W-1:0] i_iss_rd,
  input  logic [GPR_ADDR_W-1:0] i_iss_rs1,
  input  logic [GPR_ADDR_W-1:0] i_iss_rs2,
  output logic                  o_iss_stall,
  input  logic                  i_exu_valid,
  input  logic [GPR_ADDR_W-1:0] i_exu_rd,
  input  logic [CPU_WIDTH-1:0]  i_exu_data,
  output logic                  o_exu_ready,
  input  logic                  i_lsu_valid,
  input  logic [GPR_ADDR_W-1:0] i_lsu_rd,
  input  logic [CPU_WIDTH-1:0]  i_lsu_data,
  output logic                  o_lsu_ready,
  output logic                  o_wr_en_Rd,
  output logic [GPR_ADDR_W-1:0] o_addr_Rd,
  output logic [CPU_WIDTH-1:0]  o_data_Rd,
  output logic                  o_wb_err
);

  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_nxt;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  any_gnt;
  logic [GPR_ADDR_W-1:0] sel_rd;
  logic [CPU_WIDTH-1:0]  sel_data;
  logic                  iss_accept;

  assign req[ARB_EXU] = i_exu_valid;
  assign req[ARB_LSU] = i_lsu_valid;

  ysyx_23060191_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign o_exu_ready = gnt[ARB_EXU];
  assign o_lsu_ready = gnt[ARB_LSU];
  assign any_gnt     = |gnt;
  assign sel_rd      = gnt[ARB_LSU] ? i_lsu_rd   : i_exu_rd;
  assign sel_data    = gnt[ARB_LSU] ? i_lsu_data : i_exu_data;

  // pending[0] is never set, so rs/rd == x0 never causes a stall.
  assign o_iss_stall = i_iss_valid &
                       (pending[i_iss_rs1] | pending[i_iss_rs2] |
                        (i_iss_wen & pending[i_iss_rd]));
  assign iss_accept  = i_iss_valid & ~o_iss_stall & ~i_flush;

  // Order matters: commit-clear, then issue-set (set wins), then flush (wins over all).
  always_comb begin
    pending_nxt = pending;
    if (o_wr_en_Rd) begin
      pending_nxt[o_addr_Rd] = 1'b0;
    end
    if (iss_accept && i_iss_wen && (i_iss_rd != '0)) begin
      pending_nxt[i_iss_rd] = 1'b1;
    end
    if (i_flush) begin
      pending_nxt = '0;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Output stage: a granted request commits one cycle later; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_en_Rd <= 1'b0;
      o_addr_Rd  <= '0;
      o_data_Rd  <= '0;
    end else if (any_gnt) begin
      o_wr_en_Rd <= (sel_rd != '0);
      o_addr_Rd  <= sel_rd;
      o_data_Rd  <= sel_data;
    end else begin
      o_wr_en_Rd <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wb_err <= 1'b0;
    end else if (any_gnt && (sel_rd != '0) && !pending[sel_rd]) begin
      o_wb_err <= 1'b1;
    end
  end

endmodule
